// File: rtl/pulse_param_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// pulse_param_rx_pkg : frame constants and FSM state encodings
// Rev 1.0
// ----------------------------------------------------------------
package pulse_param_rx_pkg;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam int         PAYLOAD_LEN = 10;
  localparam int         CP_BIT      = 0;
  localparam int         BL_BIT      = 1;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    FR_HUNT    = 2'd0,
    FR_PAYLOAD = 2'd1,
    FR_CHECK   = 2'd2
  } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ----------------------------------------------------------------
// uart_rx_core : 8N1 receiver with 2-flop input synchronizer
// Rev 1.0
// ----------------------------------------------------------------
module uart_rx_core
  import pulse_param_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       fe
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            fe_q, fe_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      fe_q         <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      fe_q         <= fe_d;
    end
  end

  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    fe_d         = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-bit resample rejects glitches shorter than half a bit.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_BREAK: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign data       = shift_q;
  assign fe         = fe_q;

endmodule
`default_nettype wire

// File: rtl/pulse_param_rx.sv
`default_nettype none
// ----------------------------------------------------------------
// pulse_param_rx : UART parameter-frame receiver for the pulse generator
// Rev 1.0
// ----------------------------------------------------------------
module pulse_param_rx
  import pulse_param_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 120000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        RS232_Rx,
  output logic [23:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic        cp,
  output logic        bl,
  output logic        rxd,
  output logic        frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT_CLKS);
  localparam logic [3:0]    LAST_IDX = 4'(PAYLOAD_LEN - 1);
  localparam int            NSHADOW  = PAYLOAD_LEN - 1;

  logic       byte_valid, rx_fe;
  logic [7:0] rx_byte;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (RS232_Rx),
    .byte_valid (byte_valid),
    .data       (rx_byte),
    .fe         (rx_fe)
  );

  frame_state_t  state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] timer_q, timer_d;
  // Numeric fields are shadowed bytewise; only the two used flag bits are kept.
  logic [7:0]    shadow_q [NSHADOW];
  logic [7:0]    shadow_d [NSHADOW];
  logic [1:0]    flags_q, flags_d;
  logic [23:0]   per_q, per_d;
  logic [15:0]   p1wid_q, p1wid_d, del_q, del_d, p2wid_q, p2wid_d;
  logic          cp_q, cp_d, bl_q, bl_d, rxd_q, rxd_d, frame_err_q, frame_err_d;
  logic          timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FR_HUNT;
      idx_q       <= '0;
      chk_q       <= '0;
      timer_q     <= '0;
      for (int i = 0; i < NSHADOW; i++) shadow_q[i] <= '0;
      flags_q     <= '0;
      per_q       <= '0;
      p1wid_q     <= '0;
      del_q       <= '0;
      p2wid_q     <= '0;
      cp_q        <= 1'b0;
      bl_q        <= 1'b0;
      rxd_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      timer_q     <= timer_d;
      shadow_q    <= shadow_d;
      flags_q     <= flags_d;
      per_q       <= per_d;
      p1wid_q     <= p1wid_d;
      del_q       <= del_d;
      p2wid_q     <= p2wid_d;
      cp_q        <= cp_d;
      bl_q        <= bl_d;
      rxd_q       <= rxd_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign timeout = (timer_q == TO_VAL);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    shadow_d    = shadow_q;
    flags_d     = flags_q;
    per_d       = per_q;
    p1wid_d     = p1wid_q;
    del_d       = del_q;
    p2wid_d     = p2wid_q;
    cp_d        = cp_q;
    bl_d        = bl_q;
    rxd_d       = 1'b0;
    frame_err_d = 1'b0;

    // A byte arriving on the timeout cycle takes precedence and restarts the gap.
    if (byte_valid || state_q == FR_HUNT) timer_d = '0;
    else if (!timeout)                    timer_d = timer_q + TW'(1);
    else                                  timer_d = timer_q;

    case (state_q)
      FR_HUNT: begin
        if (byte_valid && rx_byte == FRAME_HDR) begin
          state_d = FR_PAYLOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      FR_PAYLOAD: begin
        if (byte_valid) begin
          chk_d = chk_q ^ rx_byte;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            flags_d = {rx_byte[BL_BIT], rx_byte[CP_BIT]};
            state_d = FR_CHECK;
          end else begin
            shadow_d[idx_q] = rx_byte;
          end
        end else if (rx_fe || timeout) begin
          frame_err_d = 1'b1;
          state_d     = FR_HUNT;
        end
      end
      FR_CHECK: begin
        if (byte_valid) begin
          state_d = FR_HUNT;
          if (rx_byte == chk_q) begin
            per_d   = {shadow_q[0], shadow_q[1], shadow_q[2]};
            p1wid_d = {shadow_q[3], shadow_q[4]};
            del_d   = {shadow_q[5], shadow_q[6]};
            p2wid_d = {shadow_q[7], shadow_q[8]};
            cp_d    = flags_q[CP_BIT];
            bl_d    = flags_q[BL_BIT];
            rxd_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (rx_fe || timeout) begin
          frame_err_d = 1'b1;
          state_d     = FR_HUNT;
        end
      end
      default: state_d = FR_HUNT;
    endcase
  end

  assign per       = per_q;
  assign p1wid     = p1wid_q;
  assign del       = del_q;
  assign p2wid     = p2wid_q;
  assign cp        = cp_q;
  assign bl        = bl_q;
  assign rxd       = rxd_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_param_rx.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_pulse_param_rx : table, corner-case and random frame checks
// Rev 1.0
// ----------------------------------------------------------------
module tb_pulse_param_rx;

  localparam int CPB = 24;
  localparam int TO  = 2000;

  typedef logic [7:0] frame_t [12];
  typedef struct {
    frame_t      f;
    logic [23:0] per;
    logic [15:0] p1, dl, p2;
    logic        cp, bl;
    int          n_rxd, n_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx;
  logic [23:0] per;
  logic [15:0] p1wid, del, p2wid;
  logic        cp, bl, rxd, frame_err;

  int tests = 0, fails = 0;
  int rxd_cnt = 0, err_cnt = 0;
  int cyc = 0, last_err_cyc = 0;

  logic [23:0] e_per;
  logic [15:0] e_p1, e_dl, e_p2;
  logic        e_cp, e_bl;

  pulse_param_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .RS232_Rx  (rx),
    .per       (per),
    .p1wid     (p1wid),
    .del       (del),
    .p2wid     (p2wid),
    .cp        (cp),
    .bl        (bl),
    .rxd       (rxd),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rxd === 1'b1) rxd_cnt++;
    if (frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 300000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, " per"},   32'(per),   32'(e_per));
    check({tag, " p1wid"}, 32'(p1wid), 32'(e_p1));
    check({tag, " del"},   32'(del),   32'(e_dl));
    check({tag, " p2wid"}, 32'(p2wid), 32'(e_p2));
    check({tag, " cp"},    32'(cp),    32'(e_cp));
    check({tag, " bl"},    32'(bl),    32'(e_bl));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 12; i++) send_byte(f[i], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: a frame commits iff header matches and the last byte is the XOR of the payload.
  task automatic model_frame(input frame_t f, output bit ok);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i <= 10; i++) x = x ^ f[i];
    ok = (f[0] == 8'hA5) && (f[11] == x);
    if (ok) begin
      e_per = 24'(int'(f[1]) * 65536 + int'(f[2]) * 256 + int'(f[3]));
      e_p1  = 16'(int'(f[4]) * 256 + int'(f[5]));
      e_dl  = 16'(int'(f[6]) * 256 + int'(f[7]));
      e_p2  = 16'(int'(f[8]) * 256 + int'(f[9]));
      e_cp  = (f[10] % 2) == 1;
      e_bl  = ((f[10] / 2) % 2) == 1;
    end
  endtask

  vec_t vecs[4];

  initial begin
    int r0, e0, t_end, lat;
    bit ok;
    frame_t fr;

    vecs[0].f = '{8'hA5, 8'h00, 8'h01, 8'hF4, 8'h00, 8'h0A, 8'h00, 8'h64, 8'h00, 8'h14, 8'h01, 8'h8E};
    vecs[0].per = 24'd500; vecs[0].p1 = 16'd10; vecs[0].dl = 16'd100; vecs[0].p2 = 16'd20;
    vecs[0].cp = 1'b1; vecs[0].bl = 1'b0; vecs[0].n_rxd = 1; vecs[0].n_err = 0;
    vecs[1].f = '{8'hA5, 8'h00, 8'h01, 8'hF4, 8'h00, 8'h0A, 8'h00, 8'h64, 8'h00, 8'h14, 8'h01, 8'h71};
    vecs[1].per = 24'd500; vecs[1].p1 = 16'd10; vecs[1].dl = 16'd100; vecs[1].p2 = 16'd20;
    vecs[1].cp = 1'b1; vecs[1].bl = 1'b0; vecs[1].n_rxd = 0; vecs[1].n_err = 1;
    vecs[2].f = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h02, 8'hA7};
    vecs[2].per = 24'hA5A5A5; vecs[2].p1 = 16'd1; vecs[2].dl = 16'd2; vecs[2].p2 = 16'd3;
    vecs[2].cp = 1'b0; vecs[2].bl = 1'b1; vecs[2].n_rxd = 1; vecs[2].n_err = 0;
    vecs[3].f = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFC, 8'hEA};
    vecs[3].per = 24'h123456; vecs[3].p1 = 16'hABCD; vecs[3].dl = 16'h0000; vecs[3].p2 = 16'hFFFF;
    vecs[3].cp = 1'b0; vecs[3].bl = 1'b0; vecs[3].n_rxd = 1; vecs[3].n_err = 0;

    rx = 1'b1;
    resetn = 1'b0;
    e_per = '0; e_p1 = '0; e_dl = '0; e_p2 = '0; e_cp = 1'b0; e_bl = 1'b0;
    repeat (5) @(negedge clk);
    check_outs("reset");
    check("reset rxd", 32'(rxd), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      r0 = rxd_cnt; e0 = err_cnt;
      send_frame(vecs[v].f);
      check($sformatf("vec%0d rxd cycles", v), 32'(rxd_cnt - r0), 32'(vecs[v].n_rxd));
      check($sformatf("vec%0d frame_err cycles", v), 32'(err_cnt - e0), 32'(vecs[v].n_err));
      e_per = vecs[v].per; e_p1 = vecs[v].p1; e_dl = vecs[v].dl; e_p2 = vecs[v].p2;
      e_cp = vecs[v].cp; e_bl = vecs[v].bl;
      check_outs($sformatf("vec%0d", v));
    end

    // Short low glitch while idle must produce neither a byte nor an error.
    r0 = rxd_cnt; e0 = err_cnt;
    @(negedge clk) rx = 1'b0;
    repeat (CPB / 3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch rxd", 32'(rxd_cnt - r0), 32'd0);
    check("glitch frame_err", 32'(err_cnt - e0), 32'd0);
    send_frame(vecs[0].f);
    model_frame(vecs[0].f, ok);
    check("post-glitch commit rxd", 32'(rxd_cnt - r0), 32'd1);
    check_outs("post-glitch");

    // Framing error while hunting is silent.
    e0 = err_cnt;
    send_byte(8'h33, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("hunt fe frame_err", 32'(err_cnt - e0), 32'd0);

    // Stop bit low on 5th payload byte aborts the frame.
    r0 = rxd_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(vecs[3].f[i], 1'b1);
    send_byte(vecs[3].f[5], 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("stopfail frame_err", 32'(err_cnt - e0), 32'd1);
    check("stopfail rxd", 32'(rxd_cnt - r0), 32'd0);
    check_outs("stopfail");
    send_frame(vecs[3].f);
    model_frame(vecs[3].f, ok);
    check("post-stopfail rxd", 32'(rxd_cnt - r0), 32'd1);
    check_outs("post-stopfail");

    // Inter-byte stall mid-frame trips the gap timeout.
    r0 = rxd_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(vecs[0].f[i], 1'b1);
    t_end = cyc;
    for (int k = 0; k < TO + 200 && err_cnt == e0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("timeout frame_err", 32'(err_cnt - e0), 32'd1);
    lat = last_err_cyc - t_end;
    check("timeout latency in window", 32'(lat >= TO - CPB && lat <= TO + 4), 32'd1);
    check("timeout rxd", 32'(rxd_cnt - r0), 32'd0);
    check_outs("timeout");

    // Asynchronous reset mid-frame clears everything at once.
    send_byte(8'hA5, 1'b1);
    for (int i = 1; i <= 3; i++) send_byte(vecs[2].f[i], 1'b1);
    #2 resetn = 1'b0;
    #1;
    e_per = '0; e_p1 = '0; e_dl = '0; e_p2 = '0; e_cp = 1'b0; e_bl = 1'b0;
    check_outs("midreset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rxd_cnt;
    send_frame(vecs[2].f);
    model_frame(vecs[2].f, ok);
    check("post-reset rxd", 32'(rxd_cnt - r0), 32'd1);
    check_outs("post-reset");

    // Random frames against the reference model.
    for (int n = 0; n < 6; n++) begin
      logic [7:0] x, g;
      r0 = rxd_cnt; e0 = err_cnt;
      if ($urandom_range(0, 1) == 1) begin
        do g = 8'($urandom); while (g == 8'hA5);
        send_byte(g, 1'b1);
      end
      fr[0] = 8'hA5;
      x = 8'h00;
      for (int i = 1; i <= 10; i++) begin
        fr[i] = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
        x = x ^ fr[i];
      end
      fr[11] = ($urandom_range(0, 2) == 0) ? (x ^ (8'h01 << $urandom_range(0, 7))) : x;
      send_frame(fr);
      model_frame(fr, ok);
      check($sformatf("rand%0d rxd", n), 32'(rxd_cnt - r0), ok ? 32'd1 : 32'd0);
      check($sformatf("rand%0d frame_err", n), 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
      check_outs($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
